// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory-stage load/store controller; read-modify-write for sub-word stores.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
  parameter int RAM_SEL_BIT  = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_readWrite,
  output logic [31:0] mem_dataIn,
  input  logic [31:0] mem_dataOut
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] c_LAT_LAST = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic             w_accept;
  logic             w_reqWord;
  logic             w_reqErr;
  logic             w_readDone;

  logic             r_write;
  logic             r_unsigned;
  logic             r_isByte;
  logic             r_isHalf;
  logic [1:0]       r_offset;
  logic [15:0]      r_wdata;
  logic [CNT_W-1:0] r_latCnt;
  logic [31:0]      r_memAddress;
  logic [31:0]      r_memDataIn;
  logic [31:0]      r_respRdata;
  logic             r_respErr;

  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_loadData;
  logic [31:0]      w_mask;
  logic [31:0]      w_laneData;
  logic [31:0]      w_mergedWord;

  assign w_accept   = req_valid && (r_state == ST_IDLE);
  assign w_reqWord  = req_size[1];
  assign w_reqErr   = ((req_size == 2'd1) && req_addr[0])
                    || (w_reqWord && (req_addr[1:0] != 2'b00))
                    || (req_write && !req_addr[RAM_SEL_BIT]);
  assign w_readDone = (r_latCnt == c_LAT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_reqErr)                    w_nextState = ST_RESP;
          else if (req_write && w_reqWord) w_nextState = ST_WRITE;
          else                             w_nextState = ST_READ;
        end
      end
      ST_READ: begin
        if (w_readDone) w_nextState = r_write ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: w_nextState = ST_RESP;
      ST_RESP:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Load lane extraction and sign/zero extension from the word being read.
  always_comb begin
    w_byte = mem_dataOut[7:0];
    case (r_offset)
      2'd0: w_byte = mem_dataOut[7:0];
      2'd1: w_byte = mem_dataOut[15:8];
      2'd2: w_byte = mem_dataOut[23:16];
      2'd3: w_byte = mem_dataOut[31:24];
      default: w_byte = mem_dataOut[7:0];
    endcase
    w_half = r_offset[1] ? mem_dataOut[31:16] : mem_dataOut[15:0];
    if (r_isByte) begin
      w_loadData = {{24{!r_unsigned && w_byte[7]}}, w_byte};
    end else if (r_isHalf) begin
      w_loadData = {{16{!r_unsigned && w_half[15]}}, w_half};
    end else begin
      w_loadData = mem_dataOut;
    end
  end

  // Sub-word store: replace the addressed little-endian lane in the fetched word.
  always_comb begin
    w_mask       = r_isByte ? (32'h0000_00FF << {r_offset, 3'b000})
                            : (32'h0000_FFFF << {r_offset[1], 4'b0000});
    w_laneData   = r_isByte ? {4{r_wdata[7:0]}} : {2{r_wdata}};
    w_mergedWord = (mem_dataOut & ~w_mask) | (w_laneData & w_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_isByte     <= 1'b0;
      r_isHalf     <= 1'b0;
      r_offset     <= 2'b00;
      r_wdata      <= '0;
      r_latCnt     <= '0;
      r_memAddress <= '0;
      r_memDataIn  <= '0;
      r_respRdata  <= '0;
      r_respErr    <= 1'b0;
    end else if (w_accept) begin
      r_write      <= req_write;
      r_unsigned   <= req_unsigned;
      r_isByte     <= (req_size == 2'd0);
      r_isHalf     <= (req_size == 2'd1);
      r_offset     <= req_addr[1:0];
      r_wdata      <= req_wdata[15:0];
      r_latCnt     <= '0;
      r_memAddress <= {req_addr[31:2], 2'b00};
      r_memDataIn  <= req_wdata;
      r_respRdata  <= '0;
      r_respErr    <= w_reqErr;
    end else if (r_state == ST_READ) begin
      if (w_readDone) begin
        if (r_write) r_memDataIn <= w_mergedWord;
        else         r_respRdata <= w_loadData;
      end else begin
        r_latCnt <= r_latCnt + 1'b1;
      end
    end
  end

  assign req_ready     = (r_state == ST_IDLE);
  assign resp_valid    = (r_state == ST_RESP);
  assign mem_readWrite = (r_state == ST_WRITE);
  assign resp_rdata    = r_respRdata;
  assign resp_err      = r_respErr;
  assign mem_address   = r_memAddress;
  assign mem_dataIn    = r_memDataIn;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// Testbench for load_store_unit: random requests checked against a word-array reference model.
module tb_load_store_unit;

  localparam int RAM_SEL_BIT  = 10;
  localparam int READ_LATENCY = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_readWrite;
  logic [31:0] mem_dataIn;
  logic [31:0] mem_dataOut;

  int nChecks = 0;
  int nFails  = 0;
  int wrCount = 0;

  logic [31:0] mem    [0:511];
  logic [31:0] refMem [0:511];
  logic        memLoad;

  always #5 clk = ~clk;

  load_store_unit #(.RAM_SEL_BIT(RAM_SEL_BIT), .READ_LATENCY(READ_LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_address(mem_address), .mem_readWrite(mem_readWrite),
    .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  // Asynchronous-read word memory (data valid within the cycle the address is held).
  assign mem_dataOut = mem[mem_address[10:2]];

  always @(posedge clk) begin
    if (memLoad) begin
      for (int i = 0; i < 512; i++) mem[i] <= refMem[i];
    end else if (mem_readWrite) begin
      mem[mem_address[10:2]] <= mem_dataIn;
      wrCount <= wrCount + 1;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic doTxn(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] word;
    logic [31:0] expData;
    logic        expErr;
    int          expLat;
    int          expWr;
    int          idx;
    int          off;
    int          cyc;
    int          wr0;
    idx     = int'(addr[10:2]);
    off     = int'(addr[1:0]);
    word    = refMem[idx];
    expData = 32'd0;
    expWr   = 0;
    expErr  = (sz == 2'd1 && off % 2 != 0) || (sz >= 2'd2 && off != 0) || (wr && !addr[RAM_SEL_BIT]);
    if (expErr) begin
      expLat = 1;
    end else if (!wr) begin
      expLat = READ_LATENCY + 1;
      if (sz == 2'd0) begin
        expData = (word >> (8 * off)) & 32'hFF;
        if (!uns && expData >= 32'h80) expData = expData | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        expData = (word >> (16 * (off / 2))) & 32'hFFFF;
        if (!uns && expData >= 32'h8000) expData = expData | 32'hFFFF_0000;
      end else begin
        expData = word;
      end
    end else begin
      expWr = 1;
      if (sz == 2'd0) begin
        expLat = READ_LATENCY + 2;
        refMem[idx] = (word & ~(32'hFF << (8 * off))) | ((wd & 32'hFF) << (8 * off));
      end else if (sz == 2'd1) begin
        expLat = READ_LATENCY + 2;
        refMem[idx] = (word & ~(32'hFFFF << (16 * (off / 2)))) | ((wd & 32'hFFFF) << (16 * (off / 2)));
      end else begin
        expLat = 2;
        refMem[idx] = wd;
      end
    end

    checkVal("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    wr0 = wrCount;
    @(negedge clk);
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      checkVal("ready_busy", 32'(req_ready), 32'd0);
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_size  = 2'($urandom_range(0, 3));
      req_addr  = $urandom;
      req_wdata = $urandom;
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    checkVal("resp_seen", 32'(resp_valid), 32'd1);
    checkVal("latency", 32'(cyc), 32'(expLat));
    checkVal("resp_err", 32'(resp_err), 32'(expErr));
    checkVal("resp_rdata", resp_rdata, expData);
    checkVal("ready_resp", 32'(req_ready), 32'd0);
    if (!expErr) checkVal("mem_address", mem_address, {addr[31:2], 2'b00});
    @(negedge clk);
    checkVal("resp_pulse", 32'(resp_valid), 32'd0);
    checkVal("wr_pulses", 32'(wrCount - wr0), 32'(expWr));
  endtask

  initial begin
    int          wr0;
    logic [31:0] addr;
    logic [1:0]  sz;
    int          off;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; memLoad = 1'b1;
    for (int i = 0; i < 512; i++) refMem[i] = $urandom;
    @(negedge clk);
    @(negedge clk);
    memLoad = 1'b0;
    checkVal("rst_ready", 32'(req_ready), 32'd1);
    checkVal("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkVal("rst_rdata", resp_rdata, 32'd0);
    checkVal("rst_err", 32'(resp_err), 32'd0);
    checkVal("rst_rw", 32'(mem_readWrite), 32'd0);
    checkVal("rst_addr", mem_address, 32'd0);
    checkVal("rst_datain", mem_dataIn, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    doTxn(1'b1, 2'd2, 1'b0, 32'h400, 32'hDEAD_BEEF);
    doTxn(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    doTxn(1'b1, 2'd2, 1'b0, 32'h404, 32'h1122_3344);
    doTxn(1'b1, 2'd0, 1'b0, 32'h405, 32'h0000_00AA);
    checkVal("rmw_word", mem[257], 32'h1122_AA44);
    doTxn(1'b1, 2'd2, 1'b0, 32'h408, 32'h1122_8044);
    doTxn(1'b0, 2'd1, 1'b0, 32'h408, 32'h0);
    doTxn(1'b0, 2'd0, 1'b1, 32'h409, 32'h0);
    doTxn(1'b1, 2'd2, 1'b0, 32'h010, 32'h1234_5678);
    doTxn(1'b0, 2'd1, 1'b0, 32'h401, 32'h0);
    doTxn(1'b1, 2'd1, 1'b0, 32'h40E, 32'hCAFE_F00D);
    doTxn(1'b0, 2'd3, 1'b0, 32'h40C, 32'h0);

    // Reset while a byte store is reading: the access must be abandoned.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h40D; req_wdata = 32'h0000_0055;
    @(negedge clk);
    req_valid = 1'b0;
    checkVal("rst_mid_busy", 32'(req_ready), 32'd0);
    wr0 = wrCount;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkVal("rst_mid_ready", 32'(req_ready), 32'd1);
    checkVal("rst_mid_rw", 32'(mem_readWrite), 32'd0);
    repeat (3) @(negedge clk);
    checkVal("rst_mid_nowrite", 32'(wrCount - wr0), 32'd0);
    checkVal("rst_mid_mem", mem[259], refMem[259]);

    for (int n = 0; n < 300; n++) begin
      sz  = 2'($urandom_range(0, 3));
      off = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) off = off & 2;
        else if (sz >= 2'd2) off = 0;
      end
      addr = ($urandom_range(0, 1) != 0 ? 32'h400 : 32'h0) + 32'($urandom_range(0, 15) * 4 + off);
      doTxn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom);
    end

    for (int i = 0; i < 16; i++) begin
      checkVal("final_rom", mem[i], refMem[i]);
      checkVal("final_ram", mem[256 + i], refMem[256 + i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
